// File: rtl/sram_port_arbiter_pkg.sv
// rtl/sram_port_arbiter_pkg.sv - shared source IDs, size encodings and grant states
package sram_port_arbiter_pkg;

    localparam logic SRC_INST = 1'b0;
    localparam logic SRC_DATA = 1'b1;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_I = 2'd1,
        LOCK_D = 2'd2
    } grant_state_e;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// rtl/sram_port_arbiter_if.sv - SRAM-like req/addr_ok/data_ok port bundle
interface sram_port_arbiter_if
    import sram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();

    logic                req;
    logic                wr;
    size_e               size;
    logic [DATA_W/8-1:0] wstrb;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic                addr_ok;
    logic                data_ok;
    logic [DATA_W-1:0]   rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/sram_port_arbiter_id_fifo.sv
// rtl/sram_port_arbiter_id_fifo.sv - in-order source-ID FIFO for outstanding transactions
module id_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    // full comes straight off the count register, so a pop never unblocks a push combinationally upstream
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - fixed-priority sharing of one SRAM-like port between fetch and data sides
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int MAX_OUTST = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic                clk,
    input  logic                reset,
    sram_port_arbiter_if.slave  inst,
    sram_port_arbiter_if.slave  data,
    sram_port_arbiter_if.master mem
);

    grant_state_e        state;
    logic                grant_src;
    logic                sel_req;
    logic                sel_wr;
    size_e               sel_size;
    logic [DATA_W/8-1:0] sel_wstrb;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                issue;
    logic                accept;
    logic                fifo_full;
    logic                fifo_empty;
    logic                head_src;
    logic                resp_ok;

    // A locked grant holds the mux until addr_ok; in IDLE the data side wins
    always_comb begin
        case (state)
            LOCK_I:  grant_src = SRC_INST;
            LOCK_D:  grant_src = SRC_DATA;
            default: grant_src = data.req ? SRC_DATA : SRC_INST;
        endcase
    end

    always_comb begin
        if (grant_src == SRC_DATA) begin
            sel_req   = data.req;
            sel_wr    = data.wr;
            sel_size  = data.size;
            sel_wstrb = data.wstrb;
            sel_addr  = data.addr;
            sel_wdata = data.wdata;
        end else begin
            sel_req   = inst.req;
            sel_wr    = inst.wr;
            sel_size  = inst.size;
            sel_wstrb = inst.wstrb;
            sel_addr  = inst.addr;
            sel_wdata = inst.wdata;
        end
    end

    assign issue  = sel_req && !fifo_full && !reset;
    assign accept = issue && mem.addr_ok;

    assign mem.req   = issue;
    assign mem.wr    = sel_wr;
    assign mem.size  = sel_size;
    assign mem.wstrb = sel_wstrb;
    assign mem.addr  = sel_addr;
    assign mem.wdata = sel_wdata;

    assign inst.addr_ok = accept && (grant_src == SRC_INST);
    assign data.addr_ok = accept && (grant_src == SRC_DATA);

    // A response with nothing outstanding is dropped rather than routed
    assign resp_ok      = mem.data_ok && !fifo_empty && !reset;
    assign inst.data_ok = resp_ok && (head_src == SRC_INST);
    assign data.data_ok = resp_ok && (head_src == SRC_DATA);
    assign inst.rdata   = mem.rdata;
    assign data.rdata   = mem.rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else if (!fifo_full) begin
            case (state)
                IDLE: begin
                    if (sel_req && !accept)
                        state <= (grant_src == SRC_DATA) ? LOCK_D : LOCK_I;
                end
                LOCK_I, LOCK_D: begin
                    if (accept) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    id_fifo #(
        .DEPTH (MAX_OUTST),
        .WIDTH (1)
    ) u_id_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .pop   (mem.data_ok),
        .din   (grant_src),
        .dout  (head_src),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - directed self-checking bench for sram_port_arbiter
module tb_sram_port_arbiter;
    import sram_port_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   sb[$];
    logic proto_err;

    sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) inst_if ();
    sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) data_if ();
    sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();

    sram_port_arbiter #(
        .MAX_OUTST (2),
        .ADDR_W    (32),
        .DATA_W    (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .inst  (inst_if),
        .data  (data_if),
        .mem   (mem_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic quiet();
        inst_if.req     = 1'b0;
        data_if.req     = 1'b0;
        mem_if.addr_ok  = 1'b0;
        mem_if.data_ok  = 1'b0;
    endtask

    task automatic chk_all_ok(input string tag, input logic ia, input logic da,
                              input logic id, input logic dd);
        chk({tag, "_inst_addr_ok"}, inst_if.addr_ok, ia);
        chk({tag, "_data_addr_ok"}, data_if.addr_ok, da);
        chk({tag, "_inst_data_ok"}, inst_if.data_ok, id);
        chk({tag, "_data_data_ok"}, data_if.data_ok, dd);
    endtask

    initial begin
        reset          = 1'b1;
        quiet();
        inst_if.wr     = 1'b0;
        inst_if.size   = SIZE_WORD;
        inst_if.wstrb  = 4'hf;
        inst_if.addr   = 32'h0;
        inst_if.wdata  = 32'h0;
        data_if.wr     = 1'b0;
        data_if.size   = SIZE_WORD;
        data_if.wstrb  = 4'hf;
        data_if.addr   = 32'h0;
        data_if.wdata  = 32'h0;
        mem_if.rdata   = 32'h0;
        proto_err      = 1'b0;

        // reset state, with a request already pending
        tick();
        data_if.req = 1'b1;
        settle();
        chk("rst_mem_req", mem_if.req, 1'b0);
        chk_all_ok("rst", 0, 0, 0, 0);
        tick();
        data_if.req = 1'b0;
        reset = 1'b0;

        // 1: idle
        for (int i = 0; i < 10; i++) begin
            settle();
            chk("t1_mem_req", mem_if.req, 1'b0);
            chk_all_ok("t1", 0, 0, 0, 0);
            tick();
        end
        chk("t1_count", dut.u_id_fifo.count, 2'd0);

        // 2: collision, data wins, responses routed in order
        inst_if.req = 1'b1; inst_if.addr = 32'h1c000000;
        data_if.req = 1'b1; data_if.addr = 32'h00001000;
        mem_if.addr_ok = 1'b1;
        settle();
        chk("t2a_mem_req", mem_if.req, 1'b1);
        chk("t2a_mem_addr", mem_if.addr, 32'h00001000);
        chk_all_ok("t2a", 0, 1, 0, 0);
        tick();
        data_if.req = 1'b0;
        settle();
        chk("t2b_mem_addr", mem_if.addr, 32'h1c000000);
        chk_all_ok("t2b", 1, 0, 0, 0);
        chk("t2b_count", dut.u_id_fifo.count, 2'd1);
        tick();
        quiet();
        chk("t2c_count", dut.u_id_fifo.count, 2'd2);
        mem_if.data_ok = 1'b1; mem_if.rdata = 32'hdeadbeef;
        settle();
        chk_all_ok("t2c", 0, 0, 0, 1);
        chk("t2c_rdata", data_if.rdata, 32'hdeadbeef);
        tick();
        mem_if.rdata = 32'h02800c0c;
        settle();
        chk_all_ok("t2d", 0, 0, 1, 0);
        chk("t2d_rdata", inst_if.rdata, 32'h02800c0c);
        tick();
        quiet();
        chk("t2e_count", dut.u_id_fifo.count, 2'd0);

        // 3: inst grant locked while data_req rises
        inst_if.req = 1'b1; inst_if.addr = 32'h1c000000;
        data_if.addr = 32'h00001000; data_if.wr = 1'b1; data_if.wstrb = 4'h3;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) data_if.req = 1'b1;
            settle();
            chk("t3_mem_req", mem_if.req, 1'b1);
            chk("t3_mem_addr", mem_if.addr, 32'h1c000000);
            chk_all_ok("t3w", 0, 0, 0, 0);
            tick();
        end
        chk("t3_state_lock", dut.state, LOCK_I);
        mem_if.addr_ok = 1'b1;
        settle();
        chk("t3_acc_addr", mem_if.addr, 32'h1c000000);
        chk("t3_acc_wr", mem_if.wr, 1'b0);
        chk_all_ok("t3acc", 1, 0, 0, 0);
        tick();
        inst_if.req = 1'b0;
        settle();
        chk("t3_d_addr", mem_if.addr, 32'h00001000);
        chk("t3_d_wr", mem_if.wr, 1'b1);
        chk("t3_d_wstrb", mem_if.wstrb, 4'h3);
        chk_all_ok("t3d", 0, 1, 0, 0);
        tick();
        quiet();
        data_if.wr = 1'b0; data_if.wstrb = 4'hf;
        mem_if.data_ok = 1'b1;
        settle();
        chk_all_ok("t3r1", 0, 0, 1, 0);
        tick();
        settle();
        chk_all_ok("t3r2", 0, 0, 0, 1);
        tick();
        quiet();

        // 4: full FIFO blocks issue until a response frees a slot
        data_if.req = 1'b1; data_if.addr = 32'h2000; mem_if.addr_ok = 1'b1;
        settle();
        chk_all_ok("t4a", 0, 1, 0, 0);
        tick();
        data_if.addr = 32'h2004;
        settle();
        chk_all_ok("t4b", 0, 1, 0, 0);
        tick();
        data_if.addr = 32'h2008;
        settle();
        chk("t4c_mem_req", mem_if.req, 1'b0);
        chk("t4c_count", dut.u_id_fifo.count, 2'd2);
        chk_all_ok("t4c", 0, 0, 0, 0);
        tick();
        mem_if.data_ok = 1'b1;
        settle();
        chk("t4d_mem_req", mem_if.req, 1'b0);
        chk_all_ok("t4d", 0, 0, 0, 1);
        tick();
        mem_if.data_ok = 1'b0;
        settle();
        chk("t4e_mem_req", mem_if.req, 1'b1);
        chk_all_ok("t4e", 0, 1, 0, 0);
        tick();
        quiet();
        mem_if.data_ok = 1'b1;
        settle();
        chk_all_ok("t4f", 0, 0, 0, 1);
        tick();
        settle();
        chk_all_ok("t4g", 0, 0, 0, 1);
        tick();
        quiet();
        chk("t4_count_end", dut.u_id_fifo.count, 2'd0);

        // 5: push and pop together at count=1, random sources
        data_if.req = 1'b1; mem_if.addr_ok = 1'b1;
        sb.push_back(1'b1);
        tick();
        for (int i = 0; i < 20; i++) begin
            bit ir, dr, exp_src, head;
            ir = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            if (!ir && !dr) ir = 1'b1;
            exp_src = dr;
            head = sb.pop_front();
            inst_if.req = ir; data_if.req = dr;
            mem_if.addr_ok = 1'b1; mem_if.data_ok = 1'b1;
            mem_if.rdata = $urandom;
            settle();
            chk_all_ok("t5", !exp_src, exp_src, !head, head);
            sb.push_back(exp_src);
            tick();
            chk("t5_count", dut.u_id_fifo.count, 2'd1);
        end
        quiet();
        mem_if.data_ok = 1'b1;
        begin
            bit head;
            head = sb.pop_front();
            settle();
            chk_all_ok("t5_drain", 0, 0, !head, head);
        end
        tick();
        quiet();
        chk("t5_count_end", dut.u_id_fifo.count, 2'd0);

        // 6: reset with two outstanding, then a stray response
        inst_if.req = 1'b1; mem_if.addr_ok = 1'b1;
        tick();
        inst_if.req = 1'b0; data_if.req = 1'b1;
        tick();
        chk("t6_count_pre", dut.u_id_fifo.count, 2'd2);
        reset = 1'b1;
        settle();
        chk("t6_rst_mem_req", mem_if.req, 1'b0);
        tick();
        reset = 1'b0;
        quiet();
        settle();
        chk("t6_state", dut.state, IDLE);
        chk("t6_count", dut.u_id_fifo.count, 2'd0);
        mem_if.data_ok = 1'b1;
        settle();
        chk_all_ok("t6_stray", 0, 0, 0, 0);
        proto_err = mem_if.data_ok && !inst_if.data_ok && !data_if.data_ok;
        chk("t6_proto_err", proto_err, 1'b1);
        tick();
        quiet();
        chk("t6_count_after", dut.u_id_fifo.count, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
